// File: rtl/mlp_rr_scheduler_pkg.sv
// Shared types and width helpers for the round-robin MLP engine scheduler.
package mlp_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    BUSY   = 3'd2,
    RETIRE = 3'd3,
    ERROR  = 3'd4
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timer must be able to hold TIMEOUT_CYCLES itself.
  function automatic int timer_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mlp_rr_scheduler_if.sv
// Requester/engine-facing signal bundle of the scheduler; slave = scheduler side.
interface mlp_rr_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 32
);
  localparam int IDX_W = mlp_sched_pkg::idx_width(NUM_REQ);

  logic                 sched_en;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   ack;
  logic                 resp_err;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic                 mlp_start;
  logic                 mlp_valid_in;
  logic                 mlp_done;
  logic                 err_flag;
  logic                 clear_err;
  logic [CNT_WIDTH-1:0] served_count;

  modport slave (
    input  sched_en, req, mlp_done, clear_err,
    output ack, resp_err, grant_valid, grant_idx, mlp_start, mlp_valid_in,
           err_flag, served_count
  );

  modport master (
    output sched_en, req, mlp_done, clear_err,
    input  ack, resp_err, grant_valid, grant_idx, mlp_start, mlp_valid_in,
           err_flag, served_count
  );
endinterface

// File: rtl/mlp_rr_scheduler_arbiter.sv
// Combinational round-robin pick: first set req strictly after last_grant, wrapping.
module rr_arbiter
  import mlp_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               any_req,
  output logic [IDX_W-1:0]   win_idx
);

  logic [NUM_REQ-1:0]   mask;
  logic [2*NUM_REQ-1:0] dbl_req;

  // Low copy holds only slots after last_grant; the high copy supplies the wrap.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i > int'(last_grant));
    end
    dbl_req = {req, req & mask};
    win_idx = '0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (dbl_req[i]) win_idx = IDX_W'(i % NUM_REQ);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mlp_rr_scheduler.sv
// Shares one MLP engine among NUM_REQ requesters: round-robin grant, issue,
// wait for done (with watchdog), then a one-cycle ack to the winner.
module mlp_rr_scheduler
  import mlp_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 32
) (
  input  logic               clk,
  input  logic               rst,
  mlp_rr_scheduler_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int TMR_W = timer_width(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [CNT_WIDTH-1:0] served_q, served_d;
  logic                 err_flag_q, err_flag_d;
  logic                 err_entry_q, err_entry_d;

  logic                 any_req;
  logic [IDX_W-1:0]     win_idx;
  logic                 ack_pulse;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .any_req    (any_req),
    .win_idx    (win_idx)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no branch can infer a latch.
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    served_d     = served_q;
    err_flag_d   = err_flag_q;
    err_entry_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.sched_en && any_req) begin
          grant_idx_d = win_idx;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // done takes priority over a coincident timeout
        if (bus.mlp_done) begin
          state_d = RETIRE;
        end else if (timer_q == TMR_LAST) begin
          state_d     = ERROR;
          err_flag_d  = 1'b1;
          err_entry_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RETIRE: begin
        last_grant_d = grant_idx_q;
        if (~&served_q) served_d = served_q + CNT_WIDTH'(1);
        state_d = IDLE;
      end
      ERROR: begin
        if (err_entry_q) last_grant_d = grant_idx_q;
        if (bus.clear_err) begin
          err_flag_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      timer_q      <= '0;
      served_q     <= '0;
      err_flag_q   <= 1'b0;
      err_entry_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      served_q     <= served_d;
      err_flag_q   <= err_flag_d;
      err_entry_q  <= err_entry_d;
    end
  end

  // err_entry_q is high only in the first ERROR cycle: the aborted job's ack.
  assign ack_pulse        = (state_q == RETIRE) || err_entry_q;
  assign bus.ack          = ack_pulse ? (NUM_REQ'(1) << grant_idx_q) : '0;
  assign bus.resp_err     = err_entry_q;
  assign bus.grant_valid  = (state_q == ISSUE) || (state_q == BUSY) || ack_pulse;
  assign bus.grant_idx    = grant_idx_q;
  assign bus.mlp_start    = (state_q == ISSUE);
  assign bus.mlp_valid_in = (state_q == ISSUE);
  assign bus.err_flag     = err_flag_q;
  assign bus.served_count = served_q;

endmodule

// File: tb/tb_mlp_rr_scheduler.sv
// Self-checking bench: scoreboard of expected grant indices for the main
// instance, directed watchdog checks on a second instance with TIMEOUT_CYCLES=16.
module tb_mlp_rr_scheduler;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mlp_rr_scheduler_if #(.NUM_REQ(N), .CNT_WIDTH(32)) bus ();
  mlp_rr_scheduler_if #(.NUM_REQ(N), .CNT_WIDTH(32)) bus2 ();

  mlp_rr_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(1024), .CNT_WIDTH(32)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  mlp_rr_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic report_fail(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur within its cycle budget", tag);
  endtask

  // Engine models: done pulses e_lat cycles after the start cycle.
  int   e_lat = 20, e_cnt;
  logic e_busy;
  int   e2_lat = 1000, e2_cnt;
  logic e2_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_busy <= 1'b0; e_cnt <= 0;
    end else if (bus.mlp_start) begin
      e_busy <= 1'b1; e_cnt <= 1;
    end else if (e_busy) begin
      if (e_cnt == e_lat) e_busy <= 1'b0;
      e_cnt <= e_cnt + 1;
    end
  end
  assign bus.mlp_done = e_busy && (e_cnt == e_lat);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e2_busy <= 1'b0; e2_cnt <= 0;
    end else if (bus2.mlp_start) begin
      e2_busy <= 1'b1; e2_cnt <= 1;
    end else if (e2_busy) begin
      if (e2_cnt == e2_lat) e2_busy <= 1'b0;
      e2_cnt <= e2_cnt + 1;
    end
  end
  assign bus2.mlp_done = e2_busy && (e2_cnt == e2_lat);

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard for the main instance.
  int exp_q[$];
  int active_idx = 0;
  int start_count = 0, ack_count = 0, stable_err = 0;
  int start_cyc = 0, ack_cyc = 0, done_cyc = 0;
  bit chk_gap = 1'b0, have_ack = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.mlp_done) done_cyc = cyc;
      if (bus.mlp_start) begin
        start_count++;
        if (chk_gap && have_ack) begin
          check("start_minus_ack", 64'(cyc - ack_cyc), 64'd2);
          check("start_minus_done", 64'(cyc - done_cyc), 64'd3);
        end
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          report_fail("unexpected_grant");
        end else begin
          active_idx = exp_q.pop_front();
          check("grant_idx", 64'(bus.grant_idx), 64'(active_idx));
          check("mlp_valid_in", 64'(bus.mlp_valid_in), 64'd1);
        end
      end
      if (bus.grant_valid && (int'(bus.grant_idx) != active_idx)) stable_err++;
      if (|bus.ack) begin
        ack_count++;
        have_ack = 1'b1;
        ack_cyc  = cyc;
        check("ack_onehot", 64'(bus.ack), 64'(N'(1) << active_idx));
        check("ack_resp_err", 64'(bus.resp_err), 64'd0);
      end
    end
  end

  // Recorder for the watchdog instance.
  int start2_cyc = 0, ack2_cyc = 0, start2_count = 0, gv2_count = 0;
  logic [N-1:0] ack2_val = '0;
  logic         err2_val = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus2.mlp_start) begin start2_count++; start2_cyc = cyc; end
      if (bus2.grant_valid) gv2_count++;
      if (|bus2.ack) begin
        ack2_val = bus2.ack;
        err2_val = bus2.resp_err;
        ack2_cyc = cyc;
      end
    end
  end

  task automatic wait_acks(input string tag, input int n, input int budget);
    int k = 0;
    int t = 0;
    while (k < n && t < budget) begin
      @(negedge clk);
      t++;
      if (|bus.ack) k++;
    end
    if (k < n) report_fail(tag);
  endtask

  task automatic wait_ack2(input string tag, input int budget);
    int t = 0;
    bit seen = 1'b0;
    while (!seen && t < budget) begin
      @(negedge clk);
      t++;
      if (|bus2.ack) seen = 1'b1;
    end
    if (!seen) report_fail(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    exp_q.delete();
    have_ack   = 1'b0;
    active_idx = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int s0, a0, g0;
    rst = 1'b1;
    bus.req = '0;  bus.sched_en = 1'b1;  bus.clear_err = 1'b0;
    bus2.req = '0; bus2.sched_en = 1'b1; bus2.clear_err = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ack",          64'(bus.ack), 64'd0);
    check("rst_resp_err",     64'(bus.resp_err), 64'd0);
    check("rst_grant_valid",  64'(bus.grant_valid), 64'd0);
    check("rst_grant_idx",    64'(bus.grant_idx), 64'd0);
    check("rst_mlp_start",    64'(bus.mlp_start), 64'd0);
    check("rst_mlp_valid_in", 64'(bus.mlp_valid_in), 64'd0);
    check("rst_err_flag",     64'(bus.err_flag), 64'd0);
    check("rst_served",       64'(bus.served_count), 64'd0);
    rst = 1'b0;

    // Single request from slot 2, engine latency 20.
    exp_q.push_back(2);
    bus.req = 4'b0100;
    wait_acks("single_ack", 1, 200);
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("single_starts",  64'(start_count), 64'd1);
    check("single_latency", 64'(ack_cyc - start_cyc), 64'd21);
    check("single_served",  64'(bus.served_count), 64'd1);
    check("single_stable",  64'(stable_err), 64'd0);

    // All requesters high for 8 jobs from a fresh reset.
    apply_reset();
    chk_gap = 1'b1;
    for (int j = 0; j < 8; j++) exp_q.push_back(j % N);
    bus.req = 4'b1111;
    wait_acks("allreq_acks", 8, 600);
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk_gap = 1'b0;
    check("allreq_served",  64'(bus.served_count), 64'd8);
    check("allreq_drained", 64'(exp_q.size()), 64'd0);
    check("allreq_stable",  64'(stable_err), 64'd0);

    // Wrap after a grant to 3, then a lone requester at 0 keeps winning.
    exp_q.push_back(0);
    bus.req = 4'b1001;
    wait_acks("wrap_ack", 1, 200);
    for (int j = 0; j < 3; j++) exp_q.push_back(0);
    bus.req = 4'b0001;
    wait_acks("lone_acks", 3, 300);
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("wrap_served",  64'(bus.served_count), 64'd12);
    check("wrap_drained", 64'(exp_q.size()), 64'd0);

    // sched_en low blocks new grants; raising it grants on the next cycle.
    bus.sched_en = 1'b0;
    bus.req = 4'b0010;
    s0 = start_count;
    repeat (10) @(negedge clk);
    check("en_off_no_start", 64'(start_count - s0), 64'd0);
    check("en_off_no_gv",    64'(bus.grant_valid), 64'd0);
    exp_q.push_back(1);
    bus.sched_en = 1'b1;
    @(negedge clk);
    check("en_on_start", 64'(bus.mlp_start), 64'd1);
    wait_acks("en_on_ack", 1, 200);
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("en_served", 64'(bus.served_count), 64'd13);

    // Reset in the middle of BUSY: outputs clear at once, no ack follows.
    exp_q.push_back(3);
    bus.req = 4'b1000;
    s0 = start_count;
    for (int t = 0; t < 20 && start_count == s0; t++) @(negedge clk);
    if (start_count == s0) report_fail("midrst_start");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_grant_valid", 64'(bus.grant_valid), 64'd0);
    check("midrst_grant_idx",   64'(bus.grant_idx), 64'd0);
    check("midrst_ack",         64'(bus.ack), 64'd0);
    check("midrst_mlp_start",   64'(bus.mlp_start), 64'd0);
    check("midrst_served",      64'(bus.served_count), 64'd0);
    exp_q.delete();
    bus.req = '0;
    a0 = ack_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_no_ack", 64'(ack_count - a0), 64'd0);
    exp_q.push_back(2);
    bus.req = 4'b1100;
    wait_acks("postrst_ack", 1, 200);
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("postrst_served", 64'(bus.served_count), 64'd1);

    // Watchdog: engine never answers, TIMEOUT_CYCLES = 16.
    e2_lat = 1000;
    bus2.req = 4'b0100;
    wait_ack2("to_ack_seen", 100);
    check("to_ack",      64'(ack2_val), 64'h4);
    check("to_resp_err", 64'(err2_val), 64'd1);
    check("to_latency",  64'(ack2_cyc - start2_cyc), 64'd17);
    check("to_err_flag", 64'(bus2.err_flag), 64'd1);
    @(negedge clk);
    s0 = start2_count;
    g0 = gv2_count;
    repeat (10) @(negedge clk);
    check("err_hold_no_start", 64'(start2_count - s0), 64'd0);
    check("err_hold_no_gv",    64'(gv2_count - g0), 64'd0);
    check("err_hold_flag",     64'(bus2.err_flag), 64'd1);
    check("err_hold_served",   64'(bus2.served_count), 64'd0);
    e2_lat = 5;
    bus2.clear_err = 1'b1;
    @(negedge clk);
    bus2.clear_err = 1'b0;
    check("clear_err_flag", 64'(bus2.err_flag), 64'd0);
    wait_ack2("after_clear_ack", 50);
    bus2.req = '0;
    check("after_clear_ack_val", 64'(ack2_val), 64'h4);
    check("after_clear_resp",    64'(err2_val), 64'd0);
    @(negedge clk);
    check("after_clear_served",  64'(bus2.served_count), 64'd1);

    // done arrives exactly on the timeout cycle: done wins.
    e2_lat = 16;
    bus2.req = 4'b0001;
    wait_ack2("coinc_ack_seen", 100);
    bus2.req = '0;
    check("coinc_ack",      64'(ack2_val), 64'h1);
    check("coinc_resp_err", 64'(err2_val), 64'd0);
    check("coinc_latency",  64'(ack2_cyc - start2_cyc), 64'd17);
    @(negedge clk);
    check("coinc_err_flag", 64'(bus2.err_flag), 64'd0);
    check("coinc_served",   64'(bus2.served_count), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "global timeout");
  end

endmodule
